// File: rtl/md_init_sequencer.sv
// Init-bank upload sequencer: forwards host stream beats step by step,
// inserting a three-cycle gap around every step-index change.
module md_init_sequencer #(
    parameter int NUM_INIT_STEPS    = 4,
    parameter int INIT_STEP_WIDTH   = 2,
    parameter int AXIS_TDATA_WIDTH  = 512,
    parameter int PARTICLE_ID_WIDTH = 9
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_start,
    input  logic                                        i_abort,
    input  logic [NUM_INIT_STEPS*PARTICLE_ID_WIDTH-1:0] i_step_count,
    input  logic [AXIS_TDATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic                                        s_axis_tvalid,
    output logic                                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]                 o_init_tdata,
    output logic                                        o_init_tvalid,
    output logic [INIT_STEP_WIDTH-1:0]                  o_init_step,
    output logic                                        o_busy,
    output logic                                        o_init_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GAP,
        DONE
    } state_t;

    localparam int CW = NUM_INIT_STEPS * PARTICLE_ID_WIDTH;
    localparam logic [INIT_STEP_WIDTH-1:0] LAST_STEP =
        INIT_STEP_WIDTH'(NUM_INIT_STEPS - 1);

    state_t                       state_q, state_d;
    logic [INIT_STEP_WIDTH-1:0]   step_q, step_d;
    logic [PARTICLE_ID_WIDTH-1:0] beat_q, beat_d;
    logic [PARTICLE_ID_WIDTH-1:0] cur_cnt;
    logic [1:0]                   gap_q, gap_d;
    logic                         final_q, final_d;
    logic [CW-1:0]                counts_q;
    logic                         hs;
    logic                         last_beat;
    logic                         empty_step;

    assign cur_cnt    = counts_q[step_q*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH];
    assign empty_step = (cur_cnt == '0);

    // An empty step never raises tready, so no beat can slip in.
    assign s_axis_tready = (state_q == LOAD) && !empty_step;
    assign hs            = s_axis_tvalid && s_axis_tready;
    assign last_beat     = hs && (beat_q == cur_cnt - 1'b1);

    assign o_busy      = (state_q == LOAD) || (state_q == GAP);
    assign o_init_done = (state_q == DONE);
    assign o_init_step = step_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        final_d = final_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD;
                    step_d  = '0;
                    beat_d  = '0;
                end
            end
            LOAD: begin
                if (i_abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                    beat_d  = '0;
                end else if (empty_step || last_beat) begin
                    state_d = GAP;
                    beat_d  = '0;
                    gap_d   = '0;
                end else if (hs) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            GAP: begin
                if (i_abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                    beat_d  = '0;
                end else begin
                    gap_d = gap_q + 2'd1;
                    // Step advances after the first gap cycle,
                    // once the last beat of the old step is out.
                    if (gap_q == 2'd0) begin
                        final_d = (step_q == LAST_STEP);
                        if (step_q != LAST_STEP) begin
                            step_d = step_q + 1'b1;
                        end
                    end
                    if (gap_q == 2'd2) begin
                        state_d = final_q ? DONE : LOAD;
                        beat_d  = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            step_q        <= '0;
            beat_q        <= '0;
            gap_q         <= '0;
            final_q       <= 1'b0;
            counts_q      <= '0;
            o_init_tvalid <= 1'b0;
            o_init_tdata  <= '0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            beat_q        <= beat_d;
            gap_q         <= gap_d;
            final_q       <= final_d;
            o_init_tvalid <= hs;
            if (hs) begin
                o_init_tdata <= s_axis_tdata;
            end
            if ((state_q == IDLE) && i_start) begin
                counts_q <= i_step_count;
            end
        end
    end

endmodule

// File: tb/tb_md_init_sequencer.sv
// Scoreboard bench for md_init_sequencer: directed uploads, abort,
// mid-gap reset and ignored restart.
module tb_md_init_sequencer;

    localparam int W  = 512;
    localparam int SW = 2;
    localparam int PW = 9;
    localparam int CW = 4 * PW;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic          i_abort;
    logic [CW-1:0] i_step_count;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  o_init_tdata;
    logic          o_init_tvalid;
    logic [SW-1:0] o_init_step;
    logic          o_busy;
    logic          o_init_done;

    md_init_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_step_count (i_step_count),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .o_init_tdata (o_init_tdata),
        .o_init_tvalid(o_init_tvalid),
        .o_init_step  (o_init_step),
        .o_busy       (o_busy),
        .o_init_done  (o_init_done)
    );

    typedef struct {
        logic [W-1:0] data;
        int           step;
        int           off;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    int   done_off = -1;
    int   st1 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk(input int tag);
        logic [31:0] t;
        t = tag;
        return {16{t}};
    endfunction

    function automatic logic [CW-1:0] pack(input int a, b, c, d);
        return {PW'(d), PW'(c), PW'(b), PW'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int tag, input int step, input int off);
        exp_t e;
        e.data = mk(tag);
        e.step = step;
        e.off  = off;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per emitted beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_init_tvalid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected beat %h step %0d",
                             o_init_tdata[31:0], o_init_step);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (o_init_tdata !== e.data ||
                        int'(o_init_step) != e.step ||
                        (e.off >= 0 && cyc - start_cyc != e.off)) begin
                        errors++;
                        $display("FAIL beat: got %h step %0d off %0d, expected %h step %0d off %0d",
                                 o_init_tdata[31:0], o_init_step,
                                 cyc - start_cyc, e.data[31:0], e.step, e.off);
                    end
                end
            end
            if (o_init_done) begin
                done_cnt++;
                done_off = cyc - start_cyc;
                checks++;
                if (o_init_step !== 2'd3 || o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_state: step %0d busy %0b, expected step 3 busy 0",
                             o_init_step, o_busy);
                end
            end
            if (o_init_step == 2'd1) st1++;
        end
    end

    task automatic start_upload(input logic [CW-1:0] cnt);
        i_step_count = cnt;
        i_start      = 1'b1;
        start_cyc    = cyc + 1;
        done_cnt     = 0;
        done_off     = -1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send_beat(input int tag, input int gap,
                             input logic abort, input logic start);
        logic rdy;
        int   n;
        repeat (gap) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = mk(tag);
        i_abort       = abort;
        i_start       = start;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 200) begin
            rdy = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("tready_timeout", 64'(n), 64'd0);
        s_axis_tvalid = 1'b0;
        i_abort       = 1'b0;
        i_start       = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("idle_after", {s_axis_tready, o_busy, o_init_step}, 64'd0);
        chk("queue_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic run_full(input int base);
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 3; j++)
                push(base + s * 3 + j, s, 1 + 6 * s + j);
        start_upload(pack(3, 3, 3, 3));
        for (int k = 0; k < 12; k++) send_beat(base + k, 0, 1'b0, 1'b0);
        wait_done();
        chk("done_offset", 64'(done_off), 64'd24);
    endtask

    int gaps[5] = '{1, 2, 0, 3, 1};
    int st2[5]  = '{0, 0, 2, 3, 3};
    int st5[6]  = '{0, 0, 1, 2, 3, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_step_count  = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {o_init_tvalid, o_init_step, o_busy,
                           o_init_done, s_axis_tready}, 64'd0);
        chk("reset_data", 64'(o_init_tdata == '0), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_full(32'h100);

        for (int k = 0; k < 5; k++) push(32'h200 + k, st2[k], -1);
        st1 = 0;
        start_upload(pack(2, 0, 1, 2));
        for (int k = 0; k < 5; k++) send_beat(32'h200 + k, gaps[k], 1'b0, 1'b0);
        wait_done();
        chk("empty_step_cycles", 64'(st1), 64'd4);

        for (int k = 0; k < 5; k++) push(32'h300 + k, 0, -1);
        start_upload(pack(8, 1, 1, 1));
        for (int k = 0; k < 4; k++) send_beat(32'h300 + k, 0, 1'b0, 1'b0);
        send_beat(32'h304, 0, 1'b1, 1'b0);
        chk("abort_state", {s_axis_tready, o_busy, o_init_step}, 64'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_beats", 64'(q.size()), 64'd0);

        for (int k = 0; k < 6; k++) push(32'h400 + k, st5[k], -1);
        start_upload(pack(2, 1, 1, 2));
        send_beat(32'h400, 0, 1'b0, 1'b0);
        i_step_count = pack(5, 5, 5, 5);
        send_beat(32'h401, 0, 1'b0, 1'b1);
        for (int k = 2; k < 6; k++) send_beat(32'h400 + k, 0, 1'b0, 1'b0);
        wait_done();

        for (int k = 0; k < 3; k++) push(32'h500 + k, k, -1);
        start_upload(pack(1, 1, 1, 1));
        for (int k = 0; k < 3; k++) send_beat(32'h500 + k, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("gap_step_before_rst", 64'(o_init_step), 64'd2);
        rst = 1'b1;
        #1;
        chk("async_rst_ctrl", {o_init_tvalid, o_init_step, o_busy,
                               o_init_done, s_axis_tready}, 64'd0);
        chk("async_rst_data", 64'(o_init_tdata == '0), 64'd1);
        chk("rst_beats", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_stays_idle", {o_busy, o_init_step, s_axis_tready}, 64'd0);

        run_full(32'h600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
